// File: rtl/hs_fifo_buffer_if.sv
// Handshake bundle for the elastic buffer: upstream push side, downstream
// pop side, flush and status. The bench holds the master end.
interface hs_fifo_buffer_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             flush;
    logic [WIDTH-1:0] in;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] out;
    logic             valid_o;
    logic             ready_i;
    logic [CW-1:0]    count;
    logic             almost_full;

    modport master (
        output flush, in, valid_i, ready_i,
        input  ready_o, out, valid_o, count, almost_full
    );

    modport slave (
        input  flush, in, valid_i, ready_i,
        output ready_o, out, valid_o, count, almost_full
    );
endinterface

// File: rtl/hs_fifo_buffer.sv
// Parametrised valid/ready elastic buffer with optional zero-latency bypass
// when empty, occupancy/almost-full status and synchronous flush.
// Full/empty come from the occupancy counter, never from pointer compare.
module hs_fifo_buffer #(
    parameter int WIDTH       = 1,
    parameter int DEPTH       = 4,
    parameter int BYPASS      = 0,
    parameter int AFULL_LEVEL = 3
) (
    input  logic          clk_core,
    input  logic          rst_core_n,
    hs_fifo_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);
    localparam bit BYP = (BYPASS != 0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic empty, full, push, pop, bypass_xfer, store, pop_mem;

    // Handshake decode; ready_o depends only on state, never on ready_i.
    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == DEPTH_C);
        bus.ready_o = ~full;
        bus.valid_o = (~empty | (BYP & bus.valid_i)) & ~bus.flush;
        bus.out     = (BYP && empty) ? bus.in : mem_q[rd_ptr_q];
        push        = bus.valid_i & ~full & ~bus.flush;
        pop         = bus.valid_o & bus.ready_i;
        // A popped word while empty can only be the bypassed incoming word.
        bypass_xfer = empty & push & pop;
        store       = push & ~bypass_xfer;
        pop_mem     = pop & ~empty;
        bus.count       = count_q;
        bus.almost_full = (count_q >= AFULL_C);
    end

    // Next pointer/occupancy state; flush wins over any push or pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store)   wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_mem) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({store, pop_mem})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk_core) begin
        if (store) mem_q[wr_ptr_q] <= bus.in;
    end
endmodule
